// File: rtl/rom_dump_controller.sv
// rom_dump_controller
//
// Sweeps every address of a 556PT5/556PT4 ROM, holds each address for
// SETTLE_CYCLES clocks, samples the chip data and streams a frame over a
// valid/ready byte interface:
//   HEADER_BYTE, data[0] .. data[2^ADDRESS_WIDTH-1], checksum
// The checksum is the 8-bit wrapping sum of the zero-extended data bytes
// (the header is not included).
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         begins a dump; only looked at while idle
//   data_line_in  chip data outputs
//   operation     chip control V1..V4, permanently "read" (4'b1100)
//   address_line  address driven to the chip
//   tx_data       stream byte
//   tx_valid      tx_data valid; held with tx_data until accepted
//   tx_ready      downstream accepts tx_data
//   busy          dump in progress
//   done          one-cycle pulse at the end of a dump

module rom_dump_controller #(
  parameter int         DATA_WIDTH    = 8,
  parameter int         ADDRESS_WIDTH = 9,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]       CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  // One spare bit on the address counter; the last address is all ones in
  // the low bits and the sweep stops there instead of wrapping.
  localparam logic [ADDRESS_WIDTH:0] ADDR_LAST  = {1'b0, {ADDRESS_WIDTH{1'b1}}};
  localparam logic [3:0]             OP_READ    = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SETUP,
    SEND,
    CHECKSUM,
    DONE
  } state_t;

  state_t                 state_q,    state_d;
  logic [ADDRESS_WIDTH:0] addr_q,     addr_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [7:0]             tx_data_q,  tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             checksum_q, checksum_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;

  logic       xfer;
  logic [7:0] data_ext;

  assign xfer = tx_valid_q && tx_ready;

  // Zero-extend chip data to a byte; written this way so DATA_WIDTH == 8
  // needs no zero-width replication.
  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = data_line_in;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    checksum_d = checksum_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = HEADER;
          addr_d     = '0;
          checksum_d = '0;
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      HEADER: begin
        if (xfer) begin
          state_d    = SETUP;
          cnt_d      = CNT_RELOAD;
          tx_valid_d = 1'b0;
        end
      end

      // Address is held; data is sampled in the last of SETTLE_CYCLES cycles.
      SETUP: begin
        if (cnt_q == '0) begin
          state_d    = SEND;
          tx_data_d  = data_ext;
          tx_valid_d = 1'b1;
          checksum_d = checksum_q + data_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SEND: begin
        if (xfer) begin
          if (addr_q == ADDR_LAST) begin
            state_d    = CHECKSUM;
            tx_data_d  = checksum_q;
            tx_valid_d = 1'b1;
          end else begin
            state_d    = SETUP;
            addr_d     = addr_q + 1'b1;
            cnt_d      = CNT_RELOAD;
            tx_valid_d = 1'b0;
          end
        end
      end

      CHECKSUM: begin
        if (xfer) begin
          state_d    = DONE;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      checksum_q <= checksum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign operation    = OP_READ;
  assign address_line = addr_q[ADDRESS_WIDTH-1:0];
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_rom_dump_controller.sv
// Testbench for rom_dump_controller.
// Instance a: default parameters (9-bit address, 8-bit data), ROM = addr^5A.
// Instance b: 8-bit address, 4-bit data, ROM = addr[3:0].
// Expected frames are queued when a dump is started and popped by a monitor
// as bytes are accepted.

module tb_rom_dump_controller;

  typedef struct packed {
    logic [7:0] val;
    logic       is_data;
  } exp_t;

  logic       clk;
  logic       reset;

  logic       start_a, tx_ready_a, tx_valid_a, busy_a, done_a;
  logic [7:0] data_a, tx_data_a;
  logic [8:0] address_line_a;
  logic [3:0] operation_a;

  logic       start_b, tx_ready_b, tx_valid_b, busy_b, done_b;
  logic [3:0] data_b;
  logic [7:0] tx_data_b, address_line_b;
  logic [3:0] operation_b;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   extra_a  = 0;
  bit   check_gap = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = '0;
  bit   last_was_data = 0;
  int   last_cyc = 0;
  exp_t mon_e;
  exp_t exp_q[$];

  rom_dump_controller dut_a (
    .clk          (clk),
    .reset        (reset),
    .start        (start_a),
    .data_line_in (data_a),
    .operation    (operation_a),
    .address_line (address_line_a),
    .tx_data      (tx_data_a),
    .tx_valid     (tx_valid_a),
    .tx_ready     (tx_ready_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  rom_dump_controller #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .start        (start_b),
    .data_line_in (data_b),
    .operation    (operation_b),
    .address_line (address_line_b),
    .tx_data      (tx_data_b),
    .tx_valid     (tx_valid_b),
    .tx_ready     (tx_ready_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  // ROM models
  assign data_a = address_line_a[7:0] ^ 8'h5A;
  assign data_b = address_line_b[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame();
    logic [7:0] sum;
    logic [7:0] v;
    sum = '0;
    exp_q.push_back({8'hA5, 1'b0});
    for (int k = 0; k < 512; k++) begin
      v   = 8'(k) ^ 8'h5A;
      sum = sum + v;
      exp_q.push_back({v, 1'b1});
    end
    exp_q.push_back({sum, 1'b0});
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_addr_a(input logic [8:0] a, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (address_line_a == a) seen = 1'b1;
    end
  endtask

  task automatic wait_done_a(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
  endtask

  task automatic finish_dump();
    bit seen;
    wait_done_a(seen);
    check("done_seen", 32'(seen), 1);
    check("busy_at_done", 32'(busy_a), 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy_a), 0);
    check("done_one_cycle", 32'(done_a), 0);
    check("addr_after_done", 32'(address_line_a), 0);
    check("frame_complete", 32'(exp_q.size()), 0);
    check("extra_bytes", 32'(extra_a), 0);
    check("done_count", 32'(done_cnt), 1);
    done_cnt = 0;
  endtask

  // Monitor / scoreboard for instance a. Inputs change just after posedge,
  // so values seen at negedge are those the next posedge acts on.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid_a), 1);
        check("hold_data", 32'(tx_data_a), 32'(prev_data));
      end
      if (done_a) done_cnt++;
      if (tx_valid_a && tx_ready_a) begin
        if (exp_q.size() == 0) begin
          extra_a++;
        end else begin
          mon_e = exp_q.pop_front();
          check("byte", 32'(tx_data_a), 32'(mon_e.val));
          if (mon_e.is_data) begin
            if (check_gap && last_was_data) check("data_gap", 32'(cyc - last_cyc), 17);
            last_cyc = cyc;
          end
          last_was_data = mon_e.is_data;
        end
      end
      prev_stall = tx_valid_a && !tx_ready_a;
      prev_data  = tx_data_a;
    end else begin
      prev_stall    = 1'b0;
      last_was_data = 1'b0;
    end
  end

  initial begin
    bit         seen;
    int         nb;
    logic [7:0] sum_b;
    logic [7:0] exp_b [258];

    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    tx_ready_a = 1'b1;
    tx_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset with start low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_addr", 32'(address_line_a), 0);
      check("rst_valid", 32'(tx_valid_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_data", 32'(tx_data_a), 0);
      check("rst_op_a", 32'(operation_a), 32'hC);
      check("rst_op_b", 32'(operation_b), 32'hC);
    end

    // Dump 1: backpressure on address 3, stray start at address 10.
    push_frame();
    pulse_start_a();
    check("busy_after_start", 32'(busy_a), 1);
    wait_addr_a(9'd3, seen);
    check("reach_addr3", 32'(seen), 1);
    @(posedge clk); #1 tx_ready_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid_a) seen = 1'b1;
    end
    check("addr3_valid", 32'(seen), 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_data", 32'(tx_data_a), 32'h59);
      check("bp_addr", 32'(address_line_a), 3);
      check("bp_valid", 32'(tx_valid_a), 1);
    end
    @(posedge clk); #1 tx_ready_a = 1'b1;
    wait_addr_a(9'd10, seen);
    check("reach_addr10", 32'(seen), 1);
    pulse_start_a();
    finish_dump();

    // Reset in the middle of a dump.
    push_frame();
    pulse_start_a();
    wait_addr_a(9'd100, seen);
    check("reach_addr100", 32'(seen), 1);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(tx_valid_a), 0);
    check("midrst_addr", 32'(address_line_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_data", 32'(tx_data_a), 0);
    check("midrst_op", 32'(operation_a), 32'hC);
    repeat (5) @(negedge clk);

    // Fresh dump with cadence checking.
    check_gap = 1'b1;
    push_frame();
    pulse_start_a();
    finish_dump();
    check_gap = 1'b0;

    // start held high: back-to-back dumps.
    push_frame();
    @(posedge clk); #1 start_a = 1'b1;
    wait_done_a(seen);
    check("held_done_seen", 32'(seen), 1);
    check("held_frame_complete", 32'(exp_q.size()), 0);
    push_frame();
    @(negedge clk);
    check("held_idle_busy", 32'(busy_a), 0);
    check("held_idle_valid", 32'(tx_valid_a), 0);
    @(negedge clk);
    check("held_hdr_valid", 32'(tx_valid_a), 1);
    check("held_hdr_data", 32'(tx_data_a), 32'hA5);
    check("held_hdr_busy", 32'(busy_a), 1);
    @(posedge clk); #1 start_a = 1'b0;
    check("held_done_count", 32'(done_cnt), 1);
    done_cnt = 0;
    finish_dump();

    // Instance b: 4-bit data, 8-bit address.
    sum_b    = '0;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 256; k++) begin
      exp_b[k+1] = {4'h0, 4'(k)};
      sum_b      = sum_b + exp_b[k+1];
    end
    exp_b[257] = sum_b;
    nb = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10000 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid_b && tx_ready_b) begin
        if (nb < 258) check("b_byte", 32'(tx_data_b), 32'(exp_b[nb]));
        if (nb >= 1 && nb <= 256) check("b_upper_nibble", 32'(tx_data_b[7:4]), 0);
        nb++;
      end
      if (done_b) seen = 1'b1;
    end
    check("b_done_seen", 32'(seen), 1);
    check("b_byte_count", 32'(nb), 258);
    @(negedge clk);
    check("b_busy_after_done", 32'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
